// File: rtl/in_service_controller.sv
// 8259 in-service stage: runs the 8086 two-pulse INTA sequence, owns the ISR and executes OCW2 EOI/rotation commands.
// Latency: ISR set / irr_clear SYNC_STAGES+1 clk edges after inta_n is sampled low; no backpressure, every event is taken when presented.
module in_service_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic [2:0] priority_id,
    input  logic       int_flag,
    input  logic       inta_n,
    input  logic       aeoi_mode,
    input  logic       ocw2_valid,
    input  logic [7:0] ocw2_data,
    output logic [7:0] isr,
    output logic [2:0] last_serviced,
    output logic       rotating_priority,
    output logic       irr_clear,
    output logic [2:0] irr_clear_id,
    output logic       vector_valid,
    output logic [2:0] vector_id,
    output logic       spurious,
    output logic       ack_busy
);

    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    logic [SYNC_STAGES-1:0] inta_sync_q;
    logic                   inta_prev_q;
    logic                   inta_s;
    logic                   inta_fall;
    logic                   inta_rise;

    state_t     state_q, state_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] last_q, last_d;
    logic       rot_q, rot_d;
    logic       rot_aeoi_q, rot_aeoi_d;
    logic [2:0] id_l_q, id_l_d;
    logic       spur_q, spur_d;
    logic       irr_clear_q, irr_clear_d;

    logic [7:0] set_mask;
    logic [7:0] ocw_clr;
    logic [7:0] aeoi_clr;
    logic       hp_hit;
    logic [2:0] hp_lvl;
    logic [2:0] scan_lvl;
    logic [2:0] ocw_cmd;
    logic [2:0] ocw_l;
    logic       unused_ocw2_bits;

    assign unused_ocw2_bits = ^ocw2_data[4:3];
    assign ocw_cmd          = ocw2_data[7:5];
    assign ocw_l            = ocw2_data[2:0];

    // inta_n is asynchronous; the chain idles high so reset never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_sync_q <= '1;
            inta_prev_q <= 1'b1;
        end else begin
            inta_sync_q[0] <= inta_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                inta_sync_q[i] <= inta_sync_q[i-1];
            end
            inta_prev_q <= inta_s;
        end
    end

    assign inta_s    = inta_sync_q[SYNC_STAGES-1];
    assign inta_fall = inta_prev_q & ~inta_s;
    assign inta_rise = ~inta_prev_q & inta_s;

    // Highest-priority in-service level: scan upward from last_serviced+1, wrapping
    always_comb begin
        hp_hit   = 1'b0;
        hp_lvl   = 3'd0;
        scan_lvl = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            scan_lvl = last_q + 3'(i + 1);
            if (isr_q[scan_lvl]) begin
                hp_hit = 1'b1;
                hp_lvl = scan_lvl;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        rot_d       = rot_q;
        rot_aeoi_d  = rot_aeoi_q;
        id_l_d      = id_l_q;
        spur_d      = spur_q;
        irr_clear_d = 1'b0;
        set_mask    = 8'h00;
        ocw_clr     = 8'h00;
        aeoi_clr    = 8'h00;

        if (ocw2_valid) begin
            case (ocw_cmd)
                3'b001: if (hp_hit) ocw_clr[hp_lvl] = 1'b1;
                3'b011: ocw_clr[ocw_l] = 1'b1;
                3'b101: begin
                    if (hp_hit) begin
                        ocw_clr[hp_lvl] = 1'b1;
                        last_d          = hp_lvl;
                        rot_d           = 1'b1;
                    end
                end
                3'b111: begin
                    ocw_clr[ocw_l] = 1'b1;
                    last_d         = ocw_l;
                    rot_d          = 1'b1;
                end
                3'b110: begin
                    last_d = ocw_l;
                    rot_d  = 1'b1;
                end
                3'b100:  rot_aeoi_d = 1'b1;
                3'b000:  rot_aeoi_d = 1'b0;
                default: ;
            endcase
        end

        // INTA-side updates come last so they override OCW2 last_serviced writes
        case (state_q)
            IDLE: begin
                if (inta_fall) begin
                    state_d = ACK1;
                    id_l_d  = int_flag ? priority_id : 3'd7;
                    spur_d  = ~int_flag;
                    if (int_flag) begin
                        set_mask[priority_id] = 1'b1;
                        irr_clear_d           = 1'b1;
                    end
                end
            end
            ACK1: if (inta_rise) state_d = GAP;
            GAP:  if (inta_fall) state_d = ACK2;
            ACK2: begin
                if (inta_rise) begin
                    state_d = IDLE;
                    if (aeoi_mode && !spur_q) begin
                        aeoi_clr[id_l_q] = 1'b1;
                        if (rot_aeoi_q) begin
                            last_d = id_l_q;
                            rot_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        isr_d = (isr_q & ~ocw_clr & ~aeoi_clr) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            isr_q       <= 8'h00;
            last_q      <= 3'd7;
            rot_q       <= 1'b0;
            rot_aeoi_q  <= 1'b0;
            id_l_q      <= 3'd0;
            spur_q      <= 1'b0;
            irr_clear_q <= 1'b0;
        end else if (init) begin
            state_q     <= IDLE;
            isr_q       <= 8'h00;
            last_q      <= 3'd7;
            rot_q       <= 1'b0;
            rot_aeoi_q  <= 1'b0;
            id_l_q      <= 3'd0;
            spur_q      <= 1'b0;
            irr_clear_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            isr_q       <= isr_d;
            last_q      <= last_d;
            rot_q       <= rot_d;
            rot_aeoi_q  <= rot_aeoi_d;
            id_l_q      <= id_l_d;
            spur_q      <= spur_d;
            irr_clear_q <= irr_clear_d;
        end
    end

    assign isr               = isr_q;
    assign last_serviced     = last_q;
    assign rotating_priority = rot_q;
    assign irr_clear         = irr_clear_q;
    assign irr_clear_id      = irr_clear_q ? id_l_q : 3'd0;
    assign vector_valid      = (state_q == ACK2);
    assign vector_id         = (state_q == ACK2) ? id_l_q : 3'd0;
    assign ack_busy          = (state_q != IDLE);
    assign spurious          = (state_q != IDLE) & spur_q;

endmodule

// File: tb/tb_in_service_controller.sv
// Directed bench for in_service_controller: irr_clear and vector presentations are scoreboarded, register state checked inline.
module tb_in_service_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init = 1'b0;
    logic [2:0] priority_id = 3'd0;
    logic       int_flag = 1'b0;
    logic       inta_n = 1'b1;
    logic       aeoi_mode = 1'b0;
    logic       ocw2_valid = 1'b0;
    logic [7:0] ocw2_data = 8'h00;
    logic [7:0] isr;
    logic [2:0] last_serviced;
    logic       rotating_priority;
    logic       irr_clear;
    logic [2:0] irr_clear_id;
    logic       vector_valid;
    logic [2:0] vector_id;
    logic       spurious;
    logic       ack_busy;

    int n_checks = 0;
    int n_fails  = 0;

    logic [2:0] exp_clr_q[$];
    logic [3:0] exp_vec_q[$];   // {spurious, vector_id}
    logic       vv_prev = 1'b0;

    in_service_controller #(.SYNC_STAGES(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .init              (init),
        .priority_id       (priority_id),
        .int_flag          (int_flag),
        .inta_n            (inta_n),
        .aeoi_mode         (aeoi_mode),
        .ocw2_valid        (ocw2_valid),
        .ocw2_data         (ocw2_data),
        .isr               (isr),
        .last_serviced     (last_serviced),
        .rotating_priority (rotating_priority),
        .irr_clear         (irr_clear),
        .irr_clear_id      (irr_clear_id),
        .vector_valid      (vector_valid),
        .vector_id         (vector_id),
        .spurious          (spurious),
        .ack_busy          (ack_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a clear pulse or a new vector
    always @(negedge clk) begin
        if (irr_clear) begin
            if (exp_clr_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_irr_clear: got id %0d, expected no pulse", irr_clear_id);
            end else begin
                chk("irr_clear_id", {5'd0, irr_clear_id}, {5'd0, exp_clr_q.pop_front()});
            end
        end
        if (vector_valid && !vv_prev) begin
            if (exp_vec_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_vector: got id %0d, expected no vector", vector_id);
            end else begin
                chk("vector_spur_id", {4'd0, spurious, vector_id}, {4'd0, exp_vec_q.pop_front()});
            end
        end
        vv_prev = vector_valid;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // First INTA pulse; returns with inta_n still low
    task automatic ack_start(input logic [2:0] id, input logic flag);
        priority_id = id;
        int_flag    = flag;
        if (flag) exp_clr_q.push_back(id);
        inta_n = 1'b0;
        wait_cyc(6);
    endtask

    // Remainder of the sequence; resolver inputs are scrambled to show id is frozen
    task automatic ack_finish(input logic [2:0] id, input logic flag);
        exp_vec_q.push_back(flag ? {1'b0, id} : 4'b1111);
        priority_id = ~id;
        int_flag    = ~flag;
        inta_n = 1'b1;
        wait_cyc(6);
        inta_n = 1'b0;
        wait_cyc(6);
        inta_n = 1'b1;
        wait_cyc(6);
        int_flag = 1'b0;
    endtask

    task automatic ocw2(input logic [7:0] d);
        ocw2_valid = 1'b1;
        ocw2_data  = d;
        wait_cyc(1);
        ocw2_valid = 1'b0;
        ocw2_data  = 8'h00;
        wait_cyc(1);
    endtask

    initial begin
        wait_cyc(2);
        chk("reset_isr", isr, 8'h00);
        chk("reset_last", {5'd0, last_serviced}, 8'd7);
        chk("reset_rot", {7'd0, rotating_priority}, 8'd0);
        chk("reset_busy", {7'd0, ack_busy}, 8'd0);
        chk("reset_vv", {7'd0, vector_valid}, 8'd0);
        rst_n = 1'b1;
        wait_cyc(2);

        // Basic acknowledge of level 3, then non-specific EOI
        ack_start(3'd3, 1'b1);
        chk("basic_isr_after_p1", isr, 8'h08);
        chk("basic_busy_p1", {7'd0, ack_busy}, 8'd1);
        ack_finish(3'd3, 1'b1);
        chk("basic_isr_done", isr, 8'h08);
        chk("basic_busy_done", {7'd0, ack_busy}, 8'd0);
        ocw2(8'h20);
        chk("basic_eoi", isr, 8'h00);

        // Nested: levels 3 then 1 in service
        ack_start(3'd3, 1'b1);
        ack_finish(3'd3, 1'b1);
        ack_start(3'd1, 1'b1);
        ack_finish(3'd1, 1'b1);
        chk("nested_isr", isr, 8'h0A);
        ocw2(8'h20);
        chk("nested_ns_eoi", isr, 8'h08);
        ocw2(8'h63);
        chk("nested_spec_eoi", isr, 8'h00);

        // Spurious: no winner at the first edge
        ack_start(3'd2, 1'b0);
        chk("spur_flag", {7'd0, spurious}, 8'd1);
        chk("spur_isr", isr, 8'h00);
        ack_finish(3'd2, 1'b0);
        chk("spur_drop", {7'd0, spurious}, 8'd0);
        chk("spur_isr_done", isr, 8'h00);

        // Set priority, then rotate on non-specific EOI
        ocw2(8'hC4);
        chk("setpri_last", {5'd0, last_serviced}, 8'd4);
        chk("setpri_rot", {7'd0, rotating_priority}, 8'd1);
        ack_start(3'd5, 1'b1);
        ack_finish(3'd5, 1'b1);
        ack_start(3'd0, 1'b1);
        ack_finish(3'd0, 1'b1);
        chk("rot_isr_pre", isr, 8'h21);
        ocw2(8'hA0);
        chk("rot_isr", isr, 8'h01);
        chk("rot_last", {5'd0, last_serviced}, 8'd5);

        // Auto-EOI with rotation, level 2
        aeoi_mode = 1'b1;
        ocw2(8'h80);
        ack_start(3'd2, 1'b1);
        chk("aeoi_isr_p1", isr, 8'h05);
        ack_finish(3'd2, 1'b1);
        chk("aeoi_isr_done", isr, 8'h01);
        chk("aeoi_last", {5'd0, last_serviced}, 8'd2);
        aeoi_mode = 1'b0;
        ocw2(8'h00);
        ocw2(8'h20);
        chk("aeoi_cleanup", isr, 8'h00);

        // Reset while in GAP aborts the sequence
        ack_start(3'd6, 1'b1);
        inta_n = 1'b1;
        wait_cyc(6);
        chk("gap_isr", isr, 8'h40);
        rst_n = 1'b0;
        #1;
        chk("midrst_isr", isr, 8'h00);
        chk("midrst_busy", {7'd0, ack_busy}, 8'd0);
        chk("midrst_last", {5'd0, last_serviced}, 8'd7);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);
        ack_start(3'd4, 1'b1);
        ack_finish(3'd4, 1'b1);
        chk("post_rst_isr", isr, 8'h10);

        // init behaves as a synchronous reset
        ocw2(8'hC1);
        init = 1'b1;
        wait_cyc(1);
        init = 1'b0;
        chk("init_isr", isr, 8'h00);
        chk("init_last", {5'd0, last_serviced}, 8'd7);
        chk("init_rot", {7'd0, rotating_priority}, 8'd0);

        wait_cyc(4);
        chk("clr_queue_empty", 8'(exp_clr_q.size()), 8'd0);
        chk("vec_queue_empty", 8'(exp_vec_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/in_service_controller.md
Name: in_service_controller

Overview:
- Sequential stage directly downstream of the priority resolver in the 8259 PIC.
- Consumes the resolver's winning ID and interrupt flag, and runs the two-pulse 8086 INTA acknowledge sequence.
- Maintains the 8-bit In-Service Register (ISR) and executes OCW2 end-of-interrupt and rotation commands.
- Feeds isr, last_serviced and rotating_priority back to the resolver, and issues clear pulses to the IRR.

Parameters:
SYNC_STAGES, 2, number of flops synchronizing inta_n into clk; legal range 1..3.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
init  in  1  one-cycle ICW1-write pulse; synchronous re-initialisation.
priority_id  in  3  winning level from resolver.
int_flag  in  1  resolver interrupt flag.
inta_n  in  1  CPU interrupt acknowledge, active low, asynchronous.
aeoi_mode  in  1  auto-EOI enable from ICW4.
ocw2_valid  in  1  one-cycle strobe, OCW2 written.
ocw2_data  in  8  OCW2 byte: [7]=R, [6]=SL, [5]=EOI, [2:0]=L.
isr  out  8  in-service register.
last_serviced  out  3  lowest-priority level, to resolver.
rotating_priority  out  1  rotation mode, to resolver.
irr_clear  out  1  one-cycle pulse, clear IRR bit.
irr_clear_id  out  3  IRR bit to clear, valid with irr_clear.
vector_valid  out  1  high while the second INTA pulse is active.
vector_id  out  3  level whose vector is driven, valid with vector_valid.
spurious  out  1  high during a sequence with no winner.
ack_busy  out  1  high from first INTA edge until end of second pulse.

Behaviour:
- Reset (rst_n low, async) and init (sync) have identical effect:
  - isr=0, last_serviced=3'b111, rotating_priority=0, rotate_aeoi=0.
  - FSM=IDLE; all pulse outputs 0; vector_id=0.
- inta_n passes through a SYNC_STAGES-flop synchronizer, resetting to 1. Edges are detected on the synchronized signal against its previous value.
- FSM states: IDLE, ACK1, GAP, ACK2.
  - IDLE -> ACK1 on falling edge. Latch id_l = int_flag ? priority_id : 7 and spur_l = ~int_flag.
    - If ~spur_l: set isr[id_l], and pulse irr_clear with irr_clear_id=id_l for exactly one cycle.
    - ack_busy=1. spurious=spur_l.
  - ACK1 -> GAP on rising edge.
  - GAP -> ACK2 on falling edge. vector_valid=1, vector_id=id_l.
  - ACK2 -> IDLE on rising edge. vector_valid, ack_busy and spurious drop.
    - If aeoi_mode and ~spur_l: clear isr[id_l].
    - If additionally rotate_aeoi: last_serviced=id_l, rotating_priority=1.
- Latency: ISR set and irr_clear occur SYNC_STAGES+1 rising clk edges after inta_n is first sampled low.
- priority_id and int_flag are ignored outside the IDLE->ACK1 transition; id_l is frozen for the whole sequence.
- OCW2 decode on ocw2_valid, using {R,SL,EOI}:
  - 001 non-specific EOI: clear the highest-priority set ISR bit (see below); no-op if isr=0.
  - 011 specific EOI: clear isr[L].
  - 101 rotate on non-specific EOI: clear as 001. If a bit b was cleared, last_serviced=b and rotating_priority=1.
  - 111 rotate on specific EOI: clear isr[L]; last_serviced=L; rotating_priority=1.
  - 110 set priority: last_serviced=L; rotating_priority=1; isr unchanged.
  - 100: rotate_aeoi=1. 000: rotate_aeoi=0. 010: no-op.
- Highest-priority ISR bit: search from level (last_serviced+1) mod 8 upward, wrapping, ending at last_serviced. With last_serviced=7 this is plain bit-0-first order.
- Simultaneous events: OCW2 clear and INTA set/clear in the same cycle are both computed from the pre-update isr.
  - Set wins over an OCW2 clear of the same bit.
  - An AEOI clear and an OCW2 clear of the same bit are harmless.
  - An INTA-driven last_serviced update wins over an OCW2 update.
- An unexpected edge order cannot occur, since each state waits only for its own edge.
- Reset or init mid-sequence aborts it immediately; the next sequence starts with a fresh falling edge.

Test Plan:
- Basic ack: priority_id=3, int_flag=1, two INTA pulses, aeoi_mode=0 -> isr=8'h08, one irr_clear pulse with id 3, vector_valid with vector_id=3 during pulse 2; then OCW2=8'h20 -> isr=0.
- Nested EOI: isr=8'h0A (levels 1,3 acknowledged), OCW2=8'h20 -> isr=8'h08; OCW2=8'h63 -> isr=0.
- Spurious: int_flag=0 at first edge -> spurious=1, vector_id=7, isr unchanged, no irr_clear.
- Rotation: OCW2=8'hC4 -> last_serviced=4, rotating_priority=1; isr=8'h21 then OCW2=8'hA0 -> bit 5 cleared, isr=8'h01, last_serviced=5.
- AEOI rotate: aeoi_mode=1, OCW2=8'h80, ack level 2 -> isr[2] set after pulse 1, cleared after pulse 2 rising edge, last_serviced=2.
- Reset mid-sequence: rst_n low in GAP -> isr=0, ack_busy=0, last_serviced=7 immediately; next full INTA pair acknowledges normally.
